// File: rtl/mux_16x1_rr_if.sv
// Bundle for the 16-to-1 arbitrating mux: the sixteen request/data lanes plus the
// registered valid/ready output stream.
interface mux_16x1_rr_if #(
    parameter int unsigned WIDTH = 8
);
    logic [15:0]         req;
    logic [16*WIDTH-1:0] in_data;
    logic [15:0]         gnt;
    logic                out_valid;
    logic [WIDTH-1:0]    out_data;
    logic [3:0]          out_sel;
    logic                out_ready;

    modport master (
        output req, in_data, out_ready,
        input  gnt, out_valid, out_data, out_sel
    );

    modport slave (
        input  req, in_data, out_ready,
        output gnt, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_16x1_rr.sv
// Sixteen-channel round-robin arbitrating mux into a single registered valid/ready stream.
// Define MUX16_FIXED_PRIO_EN for fixed priority (channel 0 highest, pointer held at 0).
module mux_16x1_rr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_16x1_rr_if.slave  bus
);
    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e           state_q;
    logic [3:0]       ptr_q;
    logic [3:0]       sel_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    logic             load;
    logic             found;
    logic             grant;
    logic [3:0]       ch_idx;
    logic [3:0]       win_idx;
    logic [WIDTH-1:0] win_data;

    // Search starts at ptr_q and wraps naturally through the 4-bit index.
    always_comb begin
        load     = (state_q == StEmpty) || (bus.out_ready && (state_q == StFull));
        found    = 1'b0;
        ch_idx   = '0;
        win_idx  = '0;
        win_data = '0;
        for (int i = 0; i < 16; i++) begin
            ch_idx = ptr_q + 4'(i);
            if (!found && bus.req[ch_idx]) begin
                found    = 1'b1;
                win_idx  = ch_idx;
                win_data = bus.in_data[ch_idx*WIDTH +: WIDTH];
            end
        end
        grant   = rst_n && load && found;
        bus.gnt = grant ? (16'd1 << win_idx) : 16'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (grant) begin
                        state_q <= StFull;
                        valid_q <= 1'b1;
                    end
                end
                StFull: begin
                    if (bus.out_ready && !grant) begin
                        state_q <= StEmpty;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                    valid_q <= 1'b0;
                end
            endcase
            if (grant) begin
                data_q <= win_data;
                sel_q  <= win_idx;
`ifdef MUX16_FIXED_PRIO_EN
                ptr_q  <= 4'd0;
`else
                ptr_q  <= win_idx + 4'd1;
`endif
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
endmodule
